// File: rtl/edge_pkg.sv
// Shared types and defaults for the SRAM port arbiter and its access timer.
package edge_pkg;

  localparam int unsigned CNT_W                 = 4;
  localparam int unsigned ACCESS_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } sram_state_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } requester_t;

endpackage

// File: rtl/sram_access_timer.sv
// Access-cycle counter: cleared as an access starts, advanced each access cycle,
// flags the final cycle of a fixed-latency SRAM access.
module sram_access_timer
  import edge_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_last_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_last_c = (r_count == CNT_W'(ACCESS_CYCLES - 1));

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between the pixel-fetch reader and
// the result-writeback writer; each access holds its strobe for ACCESS_CYCLES.
module sram_port_arbiter
  import edge_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_grant,
  output logic              wr_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              read_enable,
  output logic              write_enable,
  output logic              access_final,
  output logic              busy
);

  sram_state_t       r_state;
  sram_state_t       w_next_state;
  requester_t        r_last_served;
  logic              w_grant_rd;
  logic              w_grant_wr;
  logic              w_last;
  logic              w_busy;
  logic              r_rd_grant;
  logic              r_wr_grant;
  logic              r_rd_valid;
  logic              r_wr_done;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;

  assign w_busy = (r_state != IDLE);

  sram_access_timer #(
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_grant_rd | w_grant_wr),
    .i_enable (w_busy),
    .o_last_c (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration only in IDLE; on contention the side not served last wins.
  always_comb begin
    w_next_state = r_state;
    w_grant_rd   = 1'b0;
    w_grant_wr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (rd_req && (!wr_req || (r_last_served == REQ_WRITE))) begin
          w_grant_rd   = 1'b1;
          w_next_state = READ;
        end else if (wr_req) begin
          w_grant_wr   = 1'b1;
          w_next_state = WRITE;
        end
      end
      READ, WRITE: begin
        if (w_last) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_served <= REQ_WRITE;
      r_rd_grant    <= 1'b0;
      r_wr_grant    <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_wr_done     <= 1'b0;
      r_rd_data     <= '0;
      r_sram_addr   <= '0;
      r_sram_wdata  <= '0;
    end else begin
      r_rd_grant <= w_grant_rd;
      r_wr_grant <= w_grant_wr;
      r_rd_valid <= (r_state == READ) && w_last;
      r_wr_done  <= (r_state == WRITE) && w_last;
      if (w_grant_rd) begin
        r_sram_addr   <= rd_addr;
        r_last_served <= REQ_READ;
      end else if (w_grant_wr) begin
        r_sram_addr   <= wr_addr;
        r_sram_wdata  <= wr_data;
        r_last_served <= REQ_WRITE;
      end
      // Read data is captured at the end of the final access cycle.
      if ((r_state == READ) && w_last) begin
        r_rd_data <= sram_rdata;
      end
    end
  end

  assign rd_grant     = r_rd_grant;
  assign wr_grant     = r_wr_grant;
  assign rd_valid     = r_rd_valid;
  assign wr_done      = r_wr_done;
  assign rd_data      = r_rd_data;
  assign sram_addr    = r_sram_addr;
  assign sram_wdata   = r_sram_wdata;
  assign read_enable  = (r_state == READ);
  assign write_enable = (r_state == WRITE);
  assign access_final = w_busy && w_last;
  assign busy         = w_busy;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter at ACCESS_CYCLES = 2 (main), 1 and 5.
module tb_sram_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] sram_rdata = '0;

  logic rq2 = 1'b0, wq2 = 1'b0;
  logic rq1 = 1'b0, wq1 = 1'b0;
  logic rq5 = 1'b0, wq5 = 1'b0;

  logic          rg2, rv2, wg2, wd2, re2, we2, af2, bz2;
  logic [DW-1:0] rdat2, sw2;
  logic [AW-1:0] sa2;
  logic          rg1, rv1, wg1, wd1, re1, we1, af1, bz1;
  logic [DW-1:0] rdat1, sw1;
  logic [AW-1:0] sa1;
  logic          rg5, rv5, wg5, wd5, re5, we5, af5, bz5;
  logic [DW-1:0] rdat5, sw5;
  logic [AW-1:0] sa5;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .rd_req(rq2), .rd_addr(rd_addr), .rd_grant(rg2), .rd_data(rdat2), .rd_valid(rv2),
    .wr_req(wq2), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wg2), .wr_done(wd2),
    .sram_addr(sa2), .sram_wdata(sw2), .sram_rdata(sram_rdata),
    .read_enable(re2), .write_enable(we2), .access_final(af2), .busy(bz2)
  );

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .rd_req(rq1), .rd_addr(rd_addr), .rd_grant(rg1), .rd_data(rdat1), .rd_valid(rv1),
    .wr_req(wq1), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wg1), .wr_done(wd1),
    .sram_addr(sa1), .sram_wdata(sw1), .sram_rdata(sram_rdata),
    .read_enable(re1), .write_enable(we1), .access_final(af1), .busy(bz1)
  );

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(5)) dut5 (
    .clk(clk), .rst(rst),
    .rd_req(rq5), .rd_addr(rd_addr), .rd_grant(rg5), .rd_data(rdat5), .rd_valid(rv5),
    .wr_req(wq5), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wg5), .wr_done(wd5),
    .sram_addr(sa5), .sram_wdata(sw5), .sram_rdata(sram_rdata),
    .read_enable(re5), .write_enable(we5), .access_final(af5), .busy(bz5)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes of one instance must never overlap.
  always @(negedge clk) begin
    if (!rst) begin
      chk("excl2", 32'(re2 & we2), 32'd0);
      chk("excl1", 32'(re1 & we1), 32'd0);
      chk("excl5", 32'(re5 & we5), 32'd0);
    end
  end

  // Requester protocol on the main instance: a pending request stays up and stable.
  logic          rd_pend = 1'b0, wr_pend = 1'b0;
  logic [AW-1:0] rd_addr_q = '0, wr_addr_q = '0;
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(rd_pend && !rg2 && (!rq2 || rd_addr != rd_addr_q)))
        else $error("protocol: rd_req dropped or changed before grant");
      assert (!(wr_pend && !wg2 && (!wq2 || wr_addr != wr_addr_q)))
        else $error("protocol: wr_req dropped or changed before grant");
    end
    rd_pend   <= !rst && rq2 && !rg2;
    wr_pend   <= !rst && wq2 && !wg2;
    rd_addr_q <= rd_addr;
    wr_addr_q <= wr_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_busy", 32'(bz2), 32'd0);
    chk("rst_en", {30'd0, re2, we2}, 32'd0);
    chk("rst_pulses", {28'd0, rg2, wg2, rv2, wd2}, 32'd0);
    chk("rst_final", 32'(af2), 32'd0);
    chk("rst_rdata", 32'(rdat2), 32'd0);
    chk("rst_addr", sa2, 32'd0);
    chk("rst_wdata", 32'(sw2), 32'd0);
    rst = 1'b0;

    // Contention straight out of reset: read first, then strict alternation.
    rq2 = 1'b1; wq2 = 1'b1;
    rd_addr = 32'h300; wr_addr = 32'h400; wr_data = 8'hA5; sram_rdata = 8'h33;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cont_rg", 32'(rg2), 32'((k % 2) == 0));
      chk("cont_wg", 32'(wg2), 32'((k % 2) == 1));
      chk("cont_addr", sa2, ((k % 2) == 0) ? 32'h300 : 32'h400);
      if (k == 3) wq2 = 1'b0;
      tick();
      chk("cont_final", 32'(af2), 32'd1);
      tick();
      chk("cont_done", {30'd0, rv2, wd2}, ((k % 2) == 0) ? 32'd2 : 32'd1);
      chk("cont_idle", 32'(bz2), 32'd0);
    end
    tick();
    chk("cont_tail_rg", 32'(rg2), 32'd1);
    rq2 = 1'b0;
    tick();
    tick();
    chk("cont_tail_rv", 32'(rv2), 32'd1);
    chk("cont_tail_rdata", 32'(rdat2), 32'h33);

    // Single read.
    tick();
    rd_addr = 32'h100; sram_rdata = 8'h5A; rq2 = 1'b1;
    tick();
    chk("rd_grant", 32'(rg2), 32'd1);
    chk("rd_en1", 32'(re2), 32'd1);
    chk("rd_addr", sa2, 32'h100);
    chk("rd_final1", 32'(af2), 32'd0);
    rq2 = 1'b0;
    tick();
    chk("rd_en2", 32'(re2), 32'd1);
    chk("rd_final2", 32'(af2), 32'd1);
    chk("rd_grant_pulse", 32'(rg2), 32'd0);
    tick();
    chk("rd_en_off", 32'(re2), 32'd0);
    chk("rd_valid", 32'(rv2), 32'd1);
    chk("rd_data", 32'(rdat2), 32'h5A);
    chk("rd_busy", 32'(bz2), 32'd0);
    tick();
    chk("rd_valid_pulse", 32'(rv2), 32'd0);
    chk("rd_data_hold", 32'(rdat2), 32'h5A);

    // Single write.
    wr_addr = 32'h2000; wr_data = 8'hFF; wq2 = 1'b1;
    tick();
    chk("wr_grant", 32'(wg2), 32'd1);
    chk("wr_en1", 32'(we2), 32'd1);
    chk("wr_wdata", 32'(sw2), 32'hFF);
    chk("wr_addr", sa2, 32'h2000);
    chk("wr_no_re1", 32'(re2), 32'd0);
    wq2 = 1'b0; sram_rdata = 8'h11;
    tick();
    chk("wr_en2", 32'(we2), 32'd1);
    chk("wr_final", 32'(af2), 32'd1);
    chk("wr_done_early", 32'(wd2), 32'd0);
    chk("wr_no_re2", 32'(re2), 32'd0);
    tick();
    chk("wr_en_off", 32'(we2), 32'd0);
    chk("wr_done", 32'(wd2), 32'd1);
    chk("wr_rdata_untouched", 32'(rdat2), 32'h5A);

    // Back-to-back reads: grant every third cycle, one enable-low gap.
    rd_addr = 32'h180; rq2 = 1'b1;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("b2b_rg", 32'(rg2), 32'd1);
      chk("b2b_en_a", 32'(re2), 32'd1);
      if (g == 2) rq2 = 1'b0;
      tick();
      chk("b2b_rg_low", 32'(rg2), 32'd0);
      chk("b2b_en_b", 32'(re2), 32'd1);
      tick();
      chk("b2b_gap", 32'(re2), 32'd0);
      chk("b2b_rv", 32'(rv2), 32'd1);
    end
    tick();
    chk("b2b_end_busy", 32'(bz2), 32'd0);
    chk("b2b_end_rg", 32'(rg2), 32'd0);

    // Reset during the first cycle of a read.
    rd_addr = 32'h40; sram_rdata = 8'h77; rq2 = 1'b1;
    tick();
    chk("mrst_rg", 32'(rg2), 32'd1);
    chk("mrst_en", 32'(re2), 32'd1);
    rq2 = 1'b0; rst = 1'b1;
    tick();
    chk("mrst_en_off", 32'(re2), 32'd0);
    chk("mrst_busy", 32'(bz2), 32'd0);
    chk("mrst_rv", 32'(rv2), 32'd0);
    chk("mrst_rdata", 32'(rdat2), 32'd0);
    chk("mrst_final", 32'(af2), 32'd0);
    rst = 1'b0;
    tick();
    chk("mrst_rv_after", 32'(rv2), 32'd0);
    chk("mrst_busy_after", 32'(bz2), 32'd0);

    // ACCESS_CYCLES = 1 write: single-cycle strobe that is also the final cycle.
    wr_addr = 32'h55; wr_data = 8'h3C; wq1 = 1'b1;
    tick();
    chk("ac1_wg", 32'(wg1), 32'd1);
    chk("ac1_rg", 32'(rg1), 32'd0);
    chk("ac1_we", 32'(we1), 32'd1);
    chk("ac1_re", 32'(re1), 32'd0);
    chk("ac1_final", 32'(af1), 32'd1);
    chk("ac1_wdata", 32'(sw1), 32'h3C);
    chk("ac1_addr", sa1, 32'h55);
    wq1 = 1'b0;
    tick();
    chk("ac1_we_off", 32'(we1), 32'd0);
    chk("ac1_final_off", 32'(af1), 32'd0);
    chk("ac1_done", 32'(wd1), 32'd1);
    chk("ac1_rv", 32'(rv1), 32'd0);
    chk("ac1_rdata", 32'(rdat1), 32'd0);
    chk("ac1_busy", 32'(bz1), 32'd0);

    // ACCESS_CYCLES = 5 read: five enable cycles, final only on the fifth.
    rd_addr = 32'h999; sram_rdata = 8'hC3; rq5 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("ac5_re", 32'(re5), 32'd1);
      chk("ac5_final", 32'(af5), 32'(i == 5));
      chk("ac5_rg", 32'(rg5), 32'(i == 1));
      chk("ac5_addr", sa5, 32'h999);
      if (i == 1) rq5 = 1'b0;
    end
    tick();
    chk("ac5_re_off", 32'(re5), 32'd0);
    chk("ac5_rv", 32'(rv5), 32'd1);
    chk("ac5_rdata", 32'(rdat5), 32'hC3);
    chk("ac5_wside", {29'd0, wg5, wd5, we5}, 32'd0);
    chk("ac5_wdata", 32'(sw5), 32'd0);
    chk("ac5_busy", 32'(bz5), 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
